spram_arbiter: RTL and testbench

Two-requester round-robin arbiter that sits directly upstream of the generic single-port RAM (`spram`), time-multiplexing its one address/data port between requester A and requester B. It drives the RAM's `we`/`en`/`addr`/`din`, captures `dout`, and returns registered read data to the requester that issued the read. Read latency is fixed and depends on whether the downstream RAM runs in synchronous-read mode, and the arbiter sustains one access per cycle in both modes.

---
 rtl/spram_arbiter_if.sv | 24 ++
 rtl/spram_arbiter.sv | 122 ++++++++++++
 tb/tb_spram_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_arbiter_if.sv
// Requester-side channel of the spram arbiter: request handshake plus read response.
// The requester uses the master modport; the arbiter uses the slave modport.
interface spram_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// One access per cycle; reads return on the issuing requester's channel
// after one cycle (combinational RAM read) or two cycles (registered RAM read).
module spram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int SYNC_READ = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    spram_arbiter_if.slave    a_if,
    spram_arbiter_if.slave    b_if,
    output logic              o_ram_we,
    output logic              o_ram_en,
    output logic [AW-1:0]     o_ram_addr,
    output logic [WIDTH-1:0]  o_ram_din,
    input  logic [WIDTH-1:0]  i_ram_dout
);

    logic             r_prio;       // 0 = A wins a tie, 1 = B wins a tie
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_we_sel;
    logic             w_vld_p0;     // granted read entering the response pipe
    logic             w_own_p0;     // 0 = A, 1 = B
    logic             r_vld_p1;
    logic             r_own_p1;
    logic             w_out_vld;
    logic             w_out_own;
    logic             w_cap;
    logic [WIDTH-1:0] r_rdata;

    // Grant selection and RAM port drive; no access is issued while in reset.
    always_comb begin
        w_grant_a  = 1'b0;
        w_grant_b  = 1'b0;
        if (!rst) begin
            if (a_if.req_valid && b_if.req_valid) begin
                w_grant_a = !r_prio;
                w_grant_b = r_prio;
            end else begin
                w_grant_a = a_if.req_valid;
                w_grant_b = b_if.req_valid;
            end
        end
        // A's inputs are shown on the RAM bus whenever B is not granted.
        w_we_sel   = w_grant_b ? b_if.req_we    : a_if.req_we;
        o_ram_addr = w_grant_b ? b_if.req_addr  : a_if.req_addr;
        o_ram_din  = w_grant_b ? b_if.req_wdata : a_if.req_wdata;
        o_ram_we   = (w_grant_a || w_grant_b) && w_we_sel;
        o_ram_en   = (w_grant_a || w_grant_b) && !w_we_sel;
        w_vld_p0   = o_ram_en;
        w_own_p0   = w_grant_b;
    end

    assign a_if.req_ready = w_grant_a;
    assign b_if.req_ready = w_grant_b;

    // Priority flips to the requester that lost (or was absent) on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_grant_a) begin
            r_prio <= 1'b1;
        end else if (w_grant_b) begin
            r_prio <= 1'b0;
        end
    end

    // ---- stage p0 -> p1: read tag registered at the end of the grant cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_own_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_p0;
            r_own_p1 <= w_own_p0;
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic r_vld_p2;
            logic r_own_p2;

            // ---- stage p1 -> p2: RAM output register is valid one cycle after the grant
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p2 <= 1'b0;
                    r_own_p2 <= 1'b0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    r_own_p2 <= r_own_p1;
                end
            end

            assign w_cap     = r_vld_p1;
            assign w_out_vld = r_vld_p2;
            assign w_out_own = r_own_p2;
        end else begin : g_comb_read
            assign w_cap     = w_vld_p0;
            assign w_out_vld = r_vld_p1;
            assign w_out_own = r_own_p1;
        end
    endgenerate

    // Shared read-data register; holds its value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_cap) begin
            r_rdata <= i_ram_dout;
        end
    end

    assign a_if.rsp_valid = w_out_vld && !w_out_own;
    assign b_if.rsp_valid = w_out_vld && w_out_own;
    assign a_if.rsp_rdata = r_rdata;
    assign b_if.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Testbench for spram_arbiter: drives identical stimulus into a combinational-read
// instance and a registered-read instance, each with its own RAM model, and checks
// both against one reference arbiter/memory with per-instance response queues.
`timescale 1ns/1ps
module tb_spram_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             a_valid, a_we, b_valid, b_we;
    logic [AW-1:0]    a_addr, b_addr;
    logic [WIDTH-1:0] a_wdata, b_wdata;

    spram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) ia0(), ib0(), ia1(), ib1();

    assign ia0.req_valid = a_valid;  assign ia1.req_valid = a_valid;
    assign ia0.req_we    = a_we;     assign ia1.req_we    = a_we;
    assign ia0.req_addr  = a_addr;   assign ia1.req_addr  = a_addr;
    assign ia0.req_wdata = a_wdata;  assign ia1.req_wdata = a_wdata;
    assign ib0.req_valid = b_valid;  assign ib1.req_valid = b_valid;
    assign ib0.req_we    = b_we;     assign ib1.req_we    = b_we;
    assign ib0.req_addr  = b_addr;   assign ib1.req_addr  = b_addr;
    assign ib0.req_wdata = b_wdata;  assign ib1.req_wdata = b_wdata;

    // RAM 0: combinational read
    logic             we0, en0;
    logic [AW-1:0]    addr0;
    logic [WIDTH-1:0] din0, dout0;
    logic [WIDTH-1:0] mem0 [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem0[i] <= '0;
        end else if (we0) begin
            mem0[addr0] <= din0;
        end
    end
    assign dout0 = mem0[addr0];

    // RAM 1: registered read
    logic             we1, en1;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] din1, dout1;
    logic [WIDTH-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem1[i] <= '0;
            dout1 <= '0;
        end else begin
            if (we1) mem1[addr1] <= din1;
            if (en1) dout1 <= mem1[addr1];
        end
    end

    spram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_READ(0)) dut0 (
        .clk(clk), .rst(rst), .a_if(ia0), .b_if(ib0),
        .o_ram_we(we0), .o_ram_en(en0), .o_ram_addr(addr0), .o_ram_din(din0),
        .i_ram_dout(dout0)
    );

    spram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_READ(1)) dut1 (
        .clk(clk), .rst(rst), .a_if(ia1), .b_if(ib1),
        .o_ram_we(we1), .o_ram_en(en1), .o_ram_addr(addr1), .o_ram_din(din1),
        .i_ram_dout(dout1)
    );

    // Reference model
    typedef struct {
        int               due;
        bit               own;    // 0 = A, 1 = B
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t             q0[$];
    rsp_t             q1[$];
    logic [WIDTH-1:0] mmem [DEPTH];
    bit               mprio;
    int               cyc;
    int               n_chk;
    int               n_pass;
    int               n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string nm, input bit ev, input bit eo, input logic [WIDTH-1:0] ed,
                           input logic av, input logic bv,
                           input logic [WIDTH-1:0] ad, input logic [WIDTH-1:0] bd);
        chk({nm, "_a_rsp_valid"}, {31'd0, av}, {31'd0, ev && !eo});
        chk({nm, "_b_rsp_valid"}, {31'd0, bv}, {31'd0, ev && eo});
        if (ev && !eo) chk({nm, "_a_rsp_rdata"}, ad, ed);
        if (ev && eo)  chk({nm, "_b_rsp_rdata"}, bd, ed);
    endtask

    // One clock cycle: called just after a falling edge with inputs already set.
    task automatic step();
        int               winner;     // 0 none, 1 A, 2 B
        bit               wwe;
        logic [AW-1:0]    waddr;
        logic [WIDTH-1:0] wdat;
        bit               ev;
        bit               eo;
        logic [WIDTH-1:0] ed;
        rsp_t             r;

        if (rst)                       winner = 0;
        else if (a_valid && b_valid)   winner = mprio ? 2 : 1;
        else if (a_valid)              winner = 1;
        else if (b_valid)              winner = 2;
        else                           winner = 0;
        wwe   = (winner == 2) ? b_we    : a_we;
        waddr = (winner == 2) ? b_addr  : a_addr;
        wdat  = (winner == 2) ? b_wdata : a_wdata;

        #1;
        chk("d0_a_ready", {31'd0, ia0.req_ready}, {31'd0, winner == 1});
        chk("d0_b_ready", {31'd0, ib0.req_ready}, {31'd0, winner == 2});
        chk("d1_a_ready", {31'd0, ia1.req_ready}, {31'd0, winner == 1});
        chk("d1_b_ready", {31'd0, ib1.req_ready}, {31'd0, winner == 2});
        chk("d0_ram_we", {31'd0, we0}, {31'd0, winner != 0 && wwe});
        chk("d0_ram_en", {31'd0, en0}, {31'd0, winner != 0 && !wwe});
        chk("d1_ram_we", {31'd0, we1}, {31'd0, winner != 0 && wwe});
        chk("d1_ram_en", {31'd0, en1}, {31'd0, winner != 0 && !wwe});
        if (winner != 0) begin
            chk("d0_ram_addr", {27'd0, addr0}, {27'd0, waddr});
            chk("d1_ram_addr", {27'd0, addr1}, {27'd0, waddr});
            if (wwe) begin
                chk("d0_ram_din", din0, wdat);
                chk("d1_ram_din", din1, wdat);
            end
        end

        if (winner != 0) begin
            if (wwe) begin
                mmem[waddr] = wdat;
            end else begin
                r.own  = (winner == 2);
                r.data = mmem[waddr];
                r.due  = cyc + 1;
                q0.push_back(r);
                r.due  = cyc + 2;
                q1.push_back(r);
            end
            mprio = (winner == 1);
        end
        if (rst) begin
            mprio = 1'b0;
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
        end

        ev = 1'b0; eo = 1'b0; ed = '0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            ev = 1'b1; eo = q0[0].own; ed = q0[0].data;
            void'(q0.pop_front());
        end
        chk_rsp("d0", ev, eo, ed, ia0.rsp_valid, ib0.rsp_valid, ia0.rsp_rdata, ib0.rsp_rdata);

        ev = 1'b0; eo = 1'b0; ed = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev = 1'b1; eo = q1[0].own; ed = q1[0].data;
            void'(q1.pop_front());
        end
        chk_rsp("d1", ev, eo, ed, ia1.rsp_valid, ib1.rsp_valid, ia1.rsp_rdata, ib1.rsp_rdata);

        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0; mprio = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        @(negedge clk);

        // Reset: readies held low even with requests pending
        a_valid = 1'b1; b_valid = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rst_d0_a_rdata", ia0.rsp_rdata, 32'h0);
        chk("rst_d0_b_rdata", ib0.rsp_rdata, 32'h0);
        chk("rst_d1_a_rdata", ia1.rsp_rdata, 32'h0);
        chk("rst_d1_b_rdata", ib1.rsp_rdata, 32'h0);

        // A writes then reads back addr 5
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 32'hDEADBEEF;
        step();
        a_we = 1'b0;
        step();
        a_valid = 1'b0;
        repeat (3) step();

        // Contended continuous reads: A addr 1 = 0x11, B addr 2 = 0x22
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 32'h11;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd2; b_wdata = 32'h22;
        step();
        a_valid = 1'b1; a_we = 1'b0;
        b_we = 1'b0;
        repeat (6) step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) step();

        // Same-cycle conflict with B holding priority
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd0;
        step();
        a_we = 1'b1; a_addr = 5'd3; a_wdata = 32'h55;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd3;
        step();
        b_valid = 1'b0;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        repeat (3) step();

        // Reset while a read is in flight
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        step();
        a_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd5;
        step();
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) step();

        // Write-only burst from B, then read-back by A
        b_valid = 1'b1; b_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_addr  = AW'(8 + i);
            b_wdata = $urandom;
            step();
        end
        b_valid = 1'b0;
        a_valid = 1'b1; a_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_addr = AW'(8 + i);
            step();
        end
        a_valid = 1'b0;
        repeat (3) step();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
